debounce_edge_detect: RTL and testbench
=======================================

Name: debounce_edge_detect

Overview:
- N-channel edge detector for asynchronous external inputs (buttons, UART/PS2 lines, handshake strobes).
- Per channel, in order: synchroniser chain, counter-based debounce filter, registered edge detection with a runtime-selectable mode.
- Outputs per channel: one-cycle EDGE pulse, debounced LEVEL, sticky PENDING flag with software clear, and a combined IRQ.
- Replaces single-channel, fixed-polarity edge detectors in the FPGA top level.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- SYNC_STAGES, 2: synchroniser flip-flops per channel (>=2).
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles a new value must persist before it is accepted (>=1; 1 means no filtering).
- RESET_LEVEL, 0: reset value of every synchroniser stage and of LEVEL (replicated to all channels).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  reset; asynchronous, active-high.
- SIGNAL  in  CHANNELS  raw asynchronous inputs.
- MODE  in  2*CHANNELS  per-channel edge select, channel i uses MODE[2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both.
- CLEAR  in  CHANNELS  per-channel PENDING clear, level-sensitive, sampled on CLK.
- LEVEL  out  CHANNELS  debounced, registered level.
- EDGE  out  CHANNELS  one-cycle pulse on an accepted edge that matches MODE.
- PENDING  out  CHANNELS  sticky edge flags.
- IRQ  out  1  OR of PENDING, registered.

Behaviour:
- Reset (async assert, sync-to-CLK use after deassert):
  - all sync stages = RESET_LEVEL; LEVEL = RESET_LEVEL; debounce counters = 0.
  - EDGE = 0, PENDING = 0, IRQ = 0.
- Synchroniser: shift chain of SYNC_STAGES flops; the last stage is the filtered sample s.
- Debounce, per channel, counter cnt of width max(1, clog2(DEBOUNCE_CYCLES)):
  - s == LEVEL: cnt <= 0.
  - s != LEVEL and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s != LEVEL and cnt == DEBOUNCE_CYCLES-1: LEVEL <= s, cnt <= 0.
  - Any return of s to LEVEL before acceptance resets cnt, so the glitch is discarded with no LEVEL change and no EDGE.
- Latency: if SIGNAL changes before clock edge 1 and stays stable, LEVEL and EDGE update on edge SYNC_STAGES+DEBOUNCE_CYCLES. Defaults: edge 6.
- Edge qualification:
  - rise = LEVEL transitions 0->1; fall = LEVEL transitions 1->0.
  - EDGE[i] is registered and asserts in the same cycle LEVEL[i] takes its new value.
  - EDGE[i] = (rise & MODE[2i]) | (fall & MODE[2i+1]); high for exactly one cycle.
- MODE:
  - Sampled on the same clock edge that updates LEVEL; a change applies to the next accepted transition.
  - LEVEL tracking continues with MODE=00; transitions accepted while off are never reported later.
- PENDING:
  - Set on the cycle EDGE[i] asserts; cleared when CLEAR[i]=1.
  - Set and clear in the same cycle: set wins, PENDING stays 1.
  - CLEAR held high with no edge keeps PENDING at 0.
- IRQ: registered OR of the next-state PENDING vector, so IRQ matches PENDING in the same cycle.
- Channels are fully independent; simultaneous edges on several channels each pulse their own EDGE and PENDING bit.
- RESET mid-debounce: the count is discarded. After release LEVEL = RESET_LEVEL; an input held at the opposite level produces an edge after the full latency, counted from release.

Decomposition:
- Shared package holds:
  - mode encodings MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11;
  - a function computing the counter width from DEBOUNCE_CYCLES.
- One sub-module, debounce_channel: synchroniser, counter, LEVEL and EDGE for a single bit, instantiated CHANNELS times via generate.
- The top keeps the PENDING, CLEAR and IRQ logic.

Test Plan (CHANNELS=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0):
- Reset with SIGNAL=4'b1111 held -> during reset LEVEL=0, EDGE=0, PENDING=0, IRQ=0. After release, all channels rise together on edge 6 with MODE=all 01: EDGE=4'b1111 for 1 cycle, PENDING=4'b1111, IRQ=1.
- Ch0, MODE=01: SIGNAL[0] 0->1 held -> LEVEL[0]=1 and EDGE[0]=1 on edge 6 only. The later 1->0 gives LEVEL[0]=0 with no EDGE.
- Ch1: glitch high for 3 cycles, then 0 -> LEVEL[1] stays 0, no EDGE[1]. A 4-cycle high pulse -> LEVEL[1] rises.
- Ch2, MODE=11: 0->1, then 1->0 after 20 cycles -> two single-cycle EDGE[2] pulses, each 6 edges after its input change.
- Ch3: PENDING[3]=1, then CLEAR[3]=1 in the same cycle as a new EDGE[3] -> PENDING[3] stays 1. CLEAR[3] the next cycle -> PENDING[3]=0, IRQ=0 if no other bits are set.
- Ch0, MODE=00 during a rise, then MODE=01 -> no EDGE and no PENDING for that rise; LEVEL[0]=1. The next fall and rise report only the rise.

Source files
------------

// File: rtl/debounce_edge_detect_pkg.sv
// Shared definitions for the debounced edge detector: edge-mode encodings
// and the debounce counter width helper.
package debounce_edge_detect_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } edge_mode_e;

    // A single-cycle filter still needs a 1-bit counter to stay well formed.
    function automatic int cnt_width(input int cycles);
        if (cycles <= 2) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_edge_detect_if.sv
// Channel bundle for the debounced edge detector: raw inputs and controls in,
// filtered level, edge pulses, sticky flags and interrupt out.
interface debounce_edge_detect_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]   SIGNAL;
    logic [2*CHANNELS-1:0] MODE;
    logic [CHANNELS-1:0]   CLEAR;
    logic [CHANNELS-1:0]   LEVEL;
    logic [CHANNELS-1:0]   EDGE;
    logic [CHANNELS-1:0]   PENDING;
    logic                  IRQ;

    modport master (
        output SIGNAL, MODE, CLEAR,
        input  LEVEL, EDGE, PENDING, IRQ
    );

    modport slave (
        input  SIGNAL, MODE, CLEAR,
        output LEVEL, EDGE, PENDING, IRQ
    );
endinterface

// File: rtl/debounce_edge_detect_channel.sv
// One input bit: synchroniser chain, persistence counter, debounced level and
// mode-qualified edge pulse (edge_next is the pulse one cycle early).
module debounce_channel
    import debounce_edge_detect_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       signal,
    input  edge_mode_e mode,
    output logic       level,
    output logic       edge_pulse,
    output logic       edge_next
);
    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   level_reg, level_next;
    logic                   edge_reg;
    logic                   sample;
    logic                   rise_en, fall_en;

    assign sample  = sync_reg[SYNC_STAGES-1];
    assign rise_en = (mode == MODE_RISE) || (mode == MODE_BOTH);
    assign fall_en = (mode == MODE_FALL) || (mode == MODE_BOTH);

    // Any sample matching the current level restarts the persistence count.
    always_comb begin
        cnt_next   = '0;
        level_next = level_reg;
        edge_next  = 1'b0;
        if (sample != level_reg) begin
            if (cnt_reg == CNT_MAX) begin
                level_next = sample;
                edge_next  = sample ? rise_en : fall_en;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_reg  <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_reg   <= '0;
            level_reg <= RESET_LEVEL;
            edge_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], signal};
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            edge_reg  <= edge_next;
        end
    end

    assign level      = level_reg;
    assign edge_pulse = edge_reg;
endmodule

// File: rtl/debounce_edge_detect.sv
// N-channel debounced edge detector: per-channel filters plus sticky PENDING
// flags with software clear and a combined registered interrupt.
module debounce_edge_detect
    import debounce_edge_detect_pkg::*;
#(
    parameter int   CHANNELS        = 4,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    debounce_edge_detect_if.slave bus
);
    logic [CHANNELS-1:0] level_w;
    logic [CHANNELS-1:0] edge_w;
    logic [CHANNELS-1:0] edge_next_w;
    logic [CHANNELS-1:0] pending_reg, pending_next;
    logic                irq_reg;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            debounce_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .RESET_LEVEL    (RESET_LEVEL)
            ) u_chan (
                .CLK       (CLK),
                .RESET     (RESET),
                .signal    (bus.SIGNAL[gi]),
                .mode      (edge_mode_e'(bus.MODE[2*gi +: 2])),
                .level     (level_w[gi]),
                .edge_pulse(edge_w[gi]),
                .edge_next (edge_next_w[gi])
            );
        end
    endgenerate

    // A new edge outranks a simultaneous clear so no event is lost.
    assign pending_next = (pending_reg & ~bus.CLEAR) | edge_next_w;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pending_reg <= '0;
            irq_reg     <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            irq_reg     <= |pending_next;
        end
    end

    assign bus.LEVEL   = level_w;
    assign bus.EDGE    = edge_w;
    assign bus.PENDING = pending_reg;
    assign bus.IRQ     = irq_reg;
endmodule

// File: tb/tb_debounce_edge_detect.sv
// Self-checking bench for debounce_edge_detect: directed scenarios plus a
// randomized run, all compared against a sliding-window reference model.
module tb_debounce_edge_detect;
    localparam int CH = 4;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int H  = S + D;
    localparam int W  = 4 * CH + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    debounce_edge_detect_if #(.CHANNELS(CH)) bus ();

    debounce_edge_detect #(
        .CHANNELS(CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .RESET_LEVEL(1'b0)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference: a level flips once the last D synchronised samples (raw
    // samples delayed by S edges) all disagree with it.
    logic [H-1:0]  m_hist [CH];
    logic [CH-1:0] m_level, m_edge, m_pend;
    logic          m_irq;

    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < CH; i++) m_hist[i] = '0;
            m_level = '0; m_edge = '0; m_pend = '0; m_irq = 1'b0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                m_hist[i] = {m_hist[i][H-2:0], bus.SIGNAL[i]};
                m_edge[i] = 1'b0;
                if (m_hist[i][H-1:S] == {D{~m_level[i]}}) begin
                    m_level[i] = ~m_level[i];
                    m_edge[i]  = m_level[i] ? bus.MODE[2*i] : bus.MODE[2*i+1];
                end
            end
            m_pend = (m_pend & ~bus.CLEAR) | m_edge;
            m_irq  = |m_pend;
        end
    endtask

    // Advance exactly one rising edge; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] obs();
        return {bus.LEVEL, bus.EDGE, bus.PENDING, bus.IRQ};
    endfunction

    function automatic logic [W-1:0] expv();
        return {m_level, m_edge, m_pend, m_irq};
    endfunction

    task automatic clear_all();
        bus.CLEAR = '1;
        tick();
        bus.CLEAR = '0;
    endtask

    task automatic test_reset();
        bus.MODE = 8'b0101_0101;
        bus.SIGNAL = '1;
        rst = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (obs() !== '0) begin
                failures++;
                $display("FAIL reset_hold got=%h exp=0", obs());
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL reset_model k=%0d got=%h exp=%h", k, obs(), expv());
            end
            checks++;
            if (bus.EDGE !== ((k == 6) ? 4'b1111 : 4'b0000)) begin
                failures++;
                $display("FAIL reset_edge k=%0d got=%b", k, bus.EDGE);
            end
        end
        checks++;
        if ({bus.LEVEL, bus.PENDING, bus.IRQ} !== {4'b1111, 4'b1111, 1'b1}) begin
            failures++;
            $display("FAIL reset_after got lvl=%b pend=%b irq=%b exp 1111 1111 1", bus.LEVEL, bus.PENDING, bus.IRQ);
        end
        clear_all();
        checks++;
        if ({bus.PENDING, bus.IRQ} !== 5'b0) begin
            failures++;
            $display("FAIL reset_clear got pend=%b irq=%b exp 0", bus.PENDING, bus.IRQ);
        end
        bus.SIGNAL = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL reset_fall k=%0d got=%h exp=%h", k, obs(), expv());
            end
        end
        $display("test_reset done lvl=%b pend=%b", bus.LEVEL, bus.PENDING);
    endtask

    task automatic test_single_rise();
        bus.SIGNAL[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL rise_model k=%0d got=%h exp=%h", k, obs(), expv());
            end
            checks++;
            if ({bus.EDGE[0], bus.LEVEL[0]} !== {(k == 6), (k >= 6)}) begin
                failures++;
                $display("FAIL rise_ch0 k=%0d got edge=%b lvl=%b", k, bus.EDGE[0], bus.LEVEL[0]);
            end
        end
        bus.SIGNAL[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (bus.EDGE[0] !== 1'b0 || obs() !== expv()) begin
                failures++;
                $display("FAIL fall_silent k=%0d got=%h exp=%h", k, obs(), expv());
            end
        end
        checks++;
        if (bus.LEVEL[0] !== 1'b0) begin
            failures++;
            $display("FAIL fall_level got=%b exp=0", bus.LEVEL[0]);
        end
        clear_all();
        $display("test_single_rise done");
    endtask

    task automatic test_glitch();
        int edges = 0;
        bit saw_high = 0;
        for (int k = 1; k <= 13; k++) begin
            bus.SIGNAL[1] = (k <= 3);
            tick();
            checks++;
            if (bus.LEVEL[1] !== 1'b0 || bus.EDGE[1] !== 1'b0 || obs() !== expv()) begin
                failures++;
                $display("FAIL glitch3 k=%0d got=%h exp=%h", k, obs(), expv());
            end
        end
        for (int k = 1; k <= 16; k++) begin
            bus.SIGNAL[1] = (k <= 4);
            tick();
            if (bus.LEVEL[1]) saw_high = 1;
            if (bus.EDGE[1]) edges++;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL pulse4_model k=%0d got=%h exp=%h", k, obs(), expv());
            end
        end
        checks++;
        if (!saw_high || edges != 1) begin
            failures++;
            $display("FAIL pulse4 got saw_high=%0d edges=%0d exp 1 1", saw_high, edges);
        end
        clear_all();
        $display("test_glitch done edges=%0d", edges);
    endtask

    task automatic test_both();
        int pos_r = -1, pos_f = -1, pulses = 0;
        bus.MODE[5:4] = 2'b11;
        for (int ph = 0; ph < 2; ph++) begin
            bus.SIGNAL[2] = (ph == 0);
            for (int k = 1; k <= 20; k++) begin
                tick();
                if (bus.EDGE[2]) begin
                    pulses++;
                    if (ph == 0) pos_r = k; else pos_f = k;
                end
                checks++;
                if (obs() !== expv()) begin
                    failures++;
                    $display("FAIL both_model ph=%0d k=%0d got=%h exp=%h", ph, k, obs(), expv());
                end
            end
        end
        checks++;
        if (pos_r != 6 || pos_f != 6 || pulses != 2) begin
            failures++;
            $display("FAIL both_pos got rise=%0d fall=%0d n=%0d exp 6 6 2", pos_r, pos_f, pulses);
        end
        clear_all();
        $display("test_both done rise=%0d fall=%0d", pos_r, pos_f);
    endtask

    task automatic test_set_clear();
        bus.MODE[7:6] = 2'b11;
        bus.SIGNAL[3] = 1'b1;
        for (int k = 1; k <= 6; k++) tick();
        checks++;
        if (bus.PENDING !== 4'b1000 || bus.IRQ !== 1'b1) begin
            failures++;
            $display("FAIL sc_set got pend=%b irq=%b exp 1000 1", bus.PENDING, bus.IRQ);
        end
        bus.SIGNAL[3] = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        bus.CLEAR[3] = 1'b1;
        tick();
        checks++;
        if (bus.EDGE[3] !== 1'b1 || bus.PENDING[3] !== 1'b1 || obs() !== expv()) begin
            failures++;
            $display("FAIL sc_setwins got=%h exp=%h", obs(), expv());
        end
        tick();
        checks++;
        if (bus.PENDING !== 4'b0000 || bus.IRQ !== 1'b0 || obs() !== expv()) begin
            failures++;
            $display("FAIL sc_clear got=%h exp=%h", obs(), expv());
        end
        bus.CLEAR = '0;
        tick();
        $display("test_set_clear done");
    endtask

    task automatic test_mode_off();
        int edges = 0;
        bus.MODE[1:0] = 2'b00;
        bus.SIGNAL[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (bus.EDGE[0] !== 1'b0 || bus.PENDING[0] !== 1'b0 || obs() !== expv()) begin
                failures++;
                $display("FAIL off_quiet k=%0d got=%h exp=%h", k, obs(), expv());
            end
        end
        checks++;
        if (bus.LEVEL[0] !== 1'b1) begin
            failures++;
            $display("FAIL off_level got=%b exp=1", bus.LEVEL[0]);
        end
        bus.MODE[1:0] = 2'b01;
        for (int k = 1; k <= 16; k++) begin
            bus.SIGNAL[0] = (k > 8);
            tick();
            if (bus.EDGE[0]) edges++;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL off_resume k=%0d got=%h exp=%h", k, obs(), expv());
            end
        end
        checks++;
        if (edges != 1 || bus.PENDING[0] !== 1'b1) begin
            failures++;
            $display("FAIL off_count got edges=%0d pend=%b exp 1 1", edges, bus.PENDING[0]);
        end
        clear_all();
        $display("test_mode_off done edges=%0d", edges);
    endtask

    task automatic test_reset_mid();
        bus.MODE = 8'b0101_0101;
        bus.SIGNAL = 4'b0011;
        tick();
        bus.SIGNAL = 4'b0010;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (obs() !== '0) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=0", obs());
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (bus.EDGE !== ((k == 6) ? 4'b0010 : 4'b0000) || obs() !== expv()) begin
                failures++;
                $display("FAIL mid_release k=%0d got=%h exp=%h", k, obs(), expv());
            end
        end
        clear_all();
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int edges = 0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(5) == 0) bus.SIGNAL[i] = ~bus.SIGNAL[i];
                bus.CLEAR[i] = ($urandom_range(7) == 0);
            end
            if (k % 50 == 0) bus.MODE = 8'($urandom);
            tick();
            edges += $countones(bus.EDGE);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL random k=%0d got=%h exp=%h", k, obs(), expv());
            end
        end
        $display("test_random done edges=%0d", edges);
    endtask

    initial begin
        bus.SIGNAL = '0;
        bus.MODE   = '0;
        bus.CLEAR  = '0;
        @(negedge clk);
        test_reset();
        test_single_rise();
        test_glitch();
        test_both();
        test_set_clear();
        test_mode_off();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
